// File: rtl/muldiv_sequencer.sv
// Iterative M-extension unit: radix-2 shift-add multiplier and restoring divider behind a small FSM.
// Optional MULDIV_FAST_MUL_EN: multiplies resolve in one cycle through a combinational multiplier.
module muldiv_sequencer #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [data_width-1:0] operand_A,
    input  logic [data_width-1:0] operand_B,
    input  logic                  flush,
    output logic [data_width-1:0] MD_result,
    output logic                  done,
    output logic                  hold_pipeline,
    output logic                  busy
);
    localparam int W     = data_width;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [2:0]       funct3_r;
    logic             sign_a_r, sign_b_r;
    logic [W-1:0]     opnd_r;
    logic [2*W-1:0]   acc_r;
    logic [W-1:0]     md_result_r;
    logic             done_r;

    logic             is_div_s, signed_a_s, signed_b_s, sign_a_s, sign_b_s;
    logic [W-1:0]     mag_a_s, mag_b_s;
    logic             div_zero_s, div_ovf_s, special_s;
    logic [W-1:0]     special_res_s;
    logic [W:0]       mul_sum_s, rem_shift_s;
    logic [W+1:0]     div_diff_s;
    logic [2*W-1:0]   step_s;
    logic [W-1:0]     final_res_s;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        neg_w = ~v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
        neg_2w = ~v + {{(2*W-1){1'b0}}, 1'b1};
    endfunction

    // Turns an unsigned magnitude result (product, or {remainder, quotient}) into the architectural value.
    function automatic logic [W-1:0] resolve(input logic [2:0] f3, input logic sa, input logic sb,
                                             input logic [2*W-1:0] raw);
        logic [2*W-1:0] prod;
        logic [W-1:0]   quo;
        logic [W-1:0]   rem;
        prod = (sa ^ sb) ? neg_2w(raw) : raw;
        quo  = (sa ^ sb) ? neg_w(raw[W-1:0]) : raw[W-1:0];
        rem  = sa ? neg_w(raw[2*W-1:W]) : raw[2*W-1:W];
        case (f3)
            3'b000:                 resolve = prod[W-1:0];
            3'b001, 3'b010, 3'b011: resolve = prod[2*W-1:W];
            3'b100, 3'b101:         resolve = quo;
            3'b110, 3'b111:         resolve = rem;
            default:                resolve = prod[W-1:0];
        endcase
    endfunction

    // Request decode: signedness, operand magnitudes and the divide corner cases.
    always_comb begin
        is_div_s   = funct3[2];
        signed_a_s = is_div_s ? ~funct3[0] : (funct3[1:0] != 2'b11);
        signed_b_s = is_div_s ? ~funct3[0] : ~funct3[1];
        sign_a_s   = signed_a_s & operand_A[W-1];
        sign_b_s   = signed_b_s & operand_B[W-1];
        mag_a_s    = sign_a_s ? neg_w(operand_A) : operand_A;
        mag_b_s    = sign_b_s ? neg_w(operand_B) : operand_B;
        div_zero_s = is_div_s & (operand_B == {W{1'b0}});
        div_ovf_s  = is_div_s & ~funct3[0] & (operand_A == {1'b1, {(W-1){1'b0}}})
                     & (operand_B == {W{1'b1}});
        special_s  = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            special_res_s = funct3[1] ? operand_A : {W{1'b1}};
        end else if (div_ovf_s) begin
            special_res_s = funct3[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};
        end else begin
            special_res_s = {W{1'b0}};
        end
    end

    // One iteration step: shift-add for multiply, shift/trial-subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        rem_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_diff_s  = {1'b0, rem_shift_s} - {2'b00, opnd_r};
        if (funct3_r[2]) begin
            if (div_diff_s[W+1]) begin
                step_s = {rem_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
            end else begin
                step_s = {div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
            end
        end else begin
            step_s = {mul_sum_s, acc_r[W-1:1]};
        end
        final_res_s = resolve(funct3_r, sign_a_r, sign_b_r, step_s);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [W-1:0] fast_res_s;

    // Single-cycle multiply path used at accept time.
    always_comb begin
        fast_res_s = resolve(funct3, sign_a_s, sign_b_s,
                             {{W{1'b0}}, mag_a_s} * {{W{1'b0}}, mag_b_s});
    end
`endif

    // Sequencer state, operand latches, accumulator and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {CNT_W{1'b0}};
            funct3_r    <= 3'b000;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            opnd_r      <= {W{1'b0}};
            acc_r       <= {(2*W){1'b0}};
            md_result_r <= {W{1'b0}};
            done_r      <= 1'b0;
        end else if (flush) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        funct3_r <= funct3;
                        sign_a_r <= sign_a_s;
                        sign_b_r <= sign_b_s;
                        count_r  <= CNT_W'(W - 1);
                        opnd_r   <= is_div_s ? mag_b_s : mag_a_s;
                        acc_r    <= {{W{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
                        if (special_s) begin
                            state_r     <= DONE;
                            md_result_r <= special_res_s;
                            done_r      <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div_s) begin
                            state_r     <= DONE;
                            md_result_r <= fast_res_s;
                            done_r      <= 1'b1;
`endif
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    acc_r <= step_s;
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_r     <= DONE;
                        md_result_r <= final_res_s;
                        done_r      <= 1'b1;
                    end else begin
                        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational on start so the issuing instruction holds from its first EX cycle.
    assign hold_pipeline = ((state_r == IDLE) & start) | (state_r == CALC);
    assign busy          = (state_r != IDLE);
    assign done          = done_r;
    assign MD_result     = md_result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (default and MULDIV_FAST_MUL_EN builds).
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] operand_A = 32'h0;
    logic [31:0] operand_B = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] MD_result;
    logic        done;
    logic        hold_pipeline;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_sequencer #(.data_width(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .operand_A(operand_A), .operand_B(operand_B), .flush(flush),
        .MD_result(MD_result), .done(done), .hold_pipeline(hold_pipeline), .busy(busy)
    );

    always #5 clk = ~clk;

    // Called at posedge+1 of an IDLE cycle (cycle 0); returns at posedge+1 of cycle lat+2.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int  n;
        bit  seen;
        funct3 = f3; operand_A = a; operand_B = b; start = 1'b1;
        @(negedge clk);
        vectors++;
        if (hold_pipeline !== 1'b1) begin
            miscompares++; $display("FAIL %s hold_at_start: got %b want 1", name, hold_pipeline);
        end
        @(posedge clk); #1; start = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n <= 100) begin
            @(negedge clk);
            if (n == 1) begin
                vectors++;
                if (hold_pipeline !== (exp_lat > 1)) begin
                    miscompares++; $display("FAIL %s hold_cycle1: got %b want %b", name, hold_pipeline, exp_lat > 1);
                end
            end
            if (done === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        vectors++;
        if (!seen || n != exp_lat) begin
            miscompares++; $display("FAIL %s latency: got %0d (seen=%b) want %0d", name, n, seen, exp_lat);
        end
        vectors++;
        if (MD_result !== exp_res) begin
            miscompares++; $display("FAIL %s result: got %h want %h", name, MD_result, exp_res);
        end
        vectors++;
        if (hold_pipeline !== 1'b0) begin
            miscompares++; $display("FAIL %s hold_in_done: got %b want 0", name, hold_pipeline);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL %s after_done: done=%b busy=%b want 0 0", name, done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (MD_result !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || hold_pipeline !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: res=%h done=%b busy=%b hold=%b want 0", MD_result, done, busy, hold_pipeline);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        run_op("mul_7_m3",  3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu_min", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu_min",3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, MUL_LAT);
    endtask

    task automatic test_div();
        run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_100_7",3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        run_op("remu_100_7",3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT);
    endtask

    task automatic test_special();
        run_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    endtask

    // Last result before this task is rem_ovf = 0; seed a known nonzero value first.
    task automatic test_flush();
        bit early_done;
        run_op("divu_seed", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        funct3 = 3'b100; operand_A = 32'd1000; operand_B = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        early_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (done === 1'b1) early_done = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (early_done || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL flush_idle: early=%b done=%b busy=%b want 0 0 0", early_done, done, busy);
        end
        vectors++;
        if (MD_result !== 32'd14) begin
            miscompares++; $display("FAIL flush_keep_result: got %h want %h", MD_result, 32'd14);
        end
        @(posedge clk); #1;
        run_op("div_after_flush", 3'b100, 32'd1000, 32'd3, 32'd333, DIV_LAT);
        funct3 = 3'b101; operand_A = 32'd9; operand_B = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL flush_beats_start: busy=%b want 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit stray_done;
        funct3 = 3'b101; operand_A = 32'd100; operand_B = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2; rst = 1'b1; #1;
        vectors++;
        if (MD_result !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || hold_pipeline !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: res=%h done=%b busy=%b hold=%b want 0", MD_result, done, busy, hold_pipeline);
        end
        @(negedge clk); rst = 1'b0;
        stray_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) stray_done = 1'b1;
        end
        vectors++;
        if (stray_done) begin
            miscompares++; $display("FAIL reset_mid_no_done: activity seen after reset, want none");
        end
        @(posedge clk); #1;
    endtask

    // start held through CALC and DONE must give exactly one done pulse; start in DONE is ignored.
    task automatic test_start_held();
        int pulses;
        int first;
        funct3 = 3'b101; operand_A = 32'd100; operand_B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        pulses = 0; first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
            @(posedge clk); #1;
            if (c == 33) start = 1'b0;
        end
        vectors++;
        if (pulses != 1 || first != DIV_LAT) begin
            miscompares++; $display("FAIL start_held: pulses=%0d at=%0d want 1 at %0d", pulses, first, DIV_LAT);
        end
        vectors++;
        if (MD_result !== 32'd14) begin
            miscompares++; $display("FAIL start_held_result: got %h want %h", MD_result, 32'd14);
        end
    endtask

    // New start raised in the DONE cycle is taken in the following IDLE cycle.
    task automatic test_back_to_back();
        int n;
        bit seen;
        funct3 = 3'b101; operand_A = 32'd50; operand_B = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        funct3 = 3'b111; operand_A = 32'd50; operand_B = 32'd8; start = 1'b1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || MD_result !== 32'd10) begin
            miscompares++; $display("FAIL b2b_first: done=%b res=%h want 1 %h", done, MD_result, 32'd10);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || hold_pipeline !== 1'b1) begin
            miscompares++; $display("FAIL b2b_idle: busy=%b hold=%b want 0 1", busy, hold_pipeline);
        end
        @(posedge clk); #1; start = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n <= 100) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        vectors++;
        if (!seen || n != DIV_LAT || MD_result !== 32'd2) begin
            miscompares++; $display("FAIL b2b_second: lat=%0d res=%h want %0d %h", n, MD_result, DIV_LAT, 32'd2);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_start_held();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
